grf_sb: RTL and testbench

- Parametrised general register file for the pipelined MIPS core.
- Generalises the 2-read/1-write GRF in three ways:
  - configurable data width, address width and read-port count;
  - same-cycle write-to-read bypass;
  - a per-register pending (scoreboard) bit, set at issue and cleared at writeback.
- Sits between the decode stage (reads, issue) and the writeback stage (writes). The hazard unit stalls decode using the RBusy outputs.

---
 rtl/grf_sb.sv | 104 ++++++++++
 tb/tb_grf_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/grf_sb.sv
// grf_sb: parametrised register file with write bypass and pending scoreboard.
// Define GRF_TRACE_EN to print a writeback trace line on every RegWrite.
module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RAddr,
    output logic [NUM_RD*DATA_W-1:0] RData,
    output logic [NUM_RD-1:0]        RBusy,
    input  logic [ADDR_W-1:0]        WAddr,
    input  logic [DATA_W-1:0]        WData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        IssueAddr,
    input  logic                     IssueEn,
    input  logic                     Flush,
    output logic [ADDR_W:0]          PendCnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wr_en;

    assign wr_en   = RegWrite && (WAddr != '0);
    assign PendCnt = cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en) begin
            mem_q[WAddr] <= WData;
        end
    end

    // Flush drops the issuing instruction too; otherwise issue beats writeback.
    always_comb begin
        pend_d = pend_q;
        if (Flush) begin
            pend_d = '0;
        end else begin
            if (wr_en) begin
                pend_d[WAddr] = 1'b0;
            end
            if (IssueEn && (IssueAddr != '0)) begin
                pend_d[IssueAddr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int k = 1; k < DEPTH; k++) begin
            cnt_d = cnt_d + (ADDR_W + 1)'(pend_d[k]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = RAddr[i*ADDR_W +: ADDR_W];
        assign hit = RegWrite && (WAddr == ra);

        always_comb begin
            RData[i*DATA_W +: DATA_W] = mem_q[ra];
            RBusy[i]                  = pend_q[ra] && !hit;
            if (ra == '0) begin
                RData[i*DATA_W +: DATA_W] = '0;
                RBusy[i]                  = 1'b0;
            end else if (hit) begin
                RData[i*DATA_W +: DATA_W] = WData;
            end
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge Clk) begin
        if (!Reset && RegWrite) begin
            $display("$%d <= %h", WAddr, WData);
        end
    end
`endif

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed self-checking bench for grf_sb (default parameters).
module tb_grf_sb;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  RAddr;
    logic [63:0] RData;
    logic [1:0]  RBusy;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic        RegWrite;
    logic [4:0]  IssueAddr;
    logic        IssueEn;
    logic        Flush;
    logic [5:0]  PendCnt;

    int total = 0;
    int bad   = 0;

    grf_sb dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RAddr     (RAddr),
        .RData     (RData),
        .RBusy     (RBusy),
        .WAddr     (WAddr),
        .WData     (WData),
        .RegWrite  (RegWrite),
        .IssueAddr (IssueAddr),
        .IssueEn   (IssueEn),
        .Flush     (Flush),
        .PendCnt   (PendCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RegWrite  = 1'b0;
        IssueEn   = 1'b0;
        Flush     = 1'b0;
        Reset     = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        RAddr = '0;
        WAddr = '0;
        WData = '0;
        RegWrite = 1'b0;
        IssueAddr = '0;
        IssueEn = 1'b0;
        Flush = 1'b0;
        tick();
        tick();
        idle();
        #1;

        for (int a = 0; a < 32; a++) begin
            RAddr = {5'(a), 5'(a)};
            #1;
            chk("rst_rd0", RData[31:0], 32'h0);
            chk("rst_rd1", RData[63:32], 32'h0);
            chk("rst_busy", {30'h0, RBusy}, 32'h0);
        end
        chk("rst_cnt", {26'h0, PendCnt}, 32'h0);

        RegWrite = 1'b1; WAddr = 5'd5; WData = 32'hDEADBEEF;
        RAddr = {5'd0, 5'd5};
        #1;
        chk("bypass5", RData[31:0], 32'hDEADBEEF);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("stored5", RData[31:0], 32'hDEADBEEF);

        RegWrite = 1'b1; WAddr = 5'd0; WData = 32'h12345678;
        RAddr = {5'd0, 5'd0};
        #1;
        chk("r0_bypass", RData[31:0], 32'h0);
        tick();
        RegWrite = 1'b0;
        IssueEn = 1'b1; IssueAddr = 5'd0;
        #1;
        chk("r0_stored", RData[31:0], 32'h0);
        tick();
        IssueEn = 1'b0;
        #1;
        chk("r0_busy", {31'h0, RBusy[0]}, 32'h0);
        chk("r0_cnt", {26'h0, PendCnt}, 32'h0);

        IssueEn = 1'b1; IssueAddr = 5'd3;
        tick();
        chk("cnt_1", {26'h0, PendCnt}, 32'd1);
        IssueAddr = 5'd7;
        tick();
        chk("cnt_2", {26'h0, PendCnt}, 32'd2);
        IssueAddr = 5'd9;
        tick();
        chk("cnt_3", {26'h0, PendCnt}, 32'd3);
        IssueEn = 1'b0;
        RAddr = {5'd7, 5'd7};
        #1;
        chk("busy7", {30'h0, RBusy}, 32'h3);

        RegWrite = 1'b1; WAddr = 5'd7; WData = 32'h0000_7777;
        RAddr = {5'd7, 5'd3};
        #1;
        chk("wb7_busy1", {31'h0, RBusy[1]}, 32'h0);
        chk("wb7_data1", RData[63:32], 32'h0000_7777);
        chk("busy3", {31'h0, RBusy[0]}, 32'h1);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("cnt_after_wb7", {26'h0, PendCnt}, 32'd2);
        chk("busy7_clear", {31'h0, RBusy[1]}, 32'h0);

        RegWrite = 1'b1; WAddr = 5'd10; WData = 32'hCAFE_0010;
        tick();
        RegWrite = 1'b0;
        RAddr = {5'd10, 5'd10};
        #1;
        chk("nonpend_data", RData[63:32], 32'hCAFE_0010);
        chk("nonpend_busy", {30'h0, RBusy}, 32'h0);
        chk("nonpend_cnt", {26'h0, PendCnt}, 32'd2);

        IssueEn = 1'b1; IssueAddr = 5'd4;
        RegWrite = 1'b1; WAddr = 5'd4; WData = 32'h0000_A5A5;
        tick();
        idle();
        RAddr = {5'd9, 5'd4};
        #1;
        chk("iw4_busy", {31'h0, RBusy[0]}, 32'h1);
        chk("iw4_data", RData[31:0], 32'h0000_A5A5);
        chk("iw4_cnt", {26'h0, PendCnt}, 32'd3);
        chk("busy9", {31'h0, RBusy[1]}, 32'h1);

        IssueEn = 1'b1; IssueAddr = 5'd3;
        tick();
        IssueEn = 1'b0;
        #1;
        chk("reissue_cnt", {26'h0, PendCnt}, 32'd3);

        Flush = 1'b1; IssueEn = 1'b1; IssueAddr = 5'd12;
        tick();
        idle();
        #1;
        chk("flush_cnt", {26'h0, PendCnt}, 32'd0);
        RAddr = {5'd9, 5'd3};
        #1;
        chk("flush_busy39", {30'h0, RBusy}, 32'h0);
        RAddr = {5'd12, 5'd12};
        #1;
        chk("flush_busy12", {30'h0, RBusy}, 32'h0);

        IssueEn = 1'b1; IssueAddr = 5'd6;
        tick();
        Reset = 1'b1; IssueAddr = 5'd8;
        RegWrite = 1'b1; WAddr = 5'd11; WData = 32'hFFFF_FFFF;
        tick();
        idle();
        RAddr = {5'd4, 5'd5};
        #1;
        chk("rst2_r5", RData[31:0], 32'h0);
        chk("rst2_r4", RData[63:32], 32'h0);
        chk("rst2_cnt", {26'h0, PendCnt}, 32'd0);
        RAddr = {5'd8, 5'd6};
        #1;
        chk("rst2_busy", {30'h0, RBusy}, 32'h0);
        RAddr = {5'd11, 5'd10};
        #1;
        chk("rst2_r10", RData[31:0], 32'h0);
        chk("rst2_r11", RData[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
